change_dispenser: RTL and testbench

Converts a change amount in cents into a sequence of physical coin-eject commands for the coin hopper, using greedy quarter/dime/nickel selection. Sits downstream of the vending controller: the controller hands over a change amount with a valid/ready handshake, and this block drives the hopper one coin at a time. Each eject waits for a hopper acknowledge, and each request finishes with a done or error pulse.

---
 rtl/change_dispenser_pkg.sv | 35 +++
 rtl/change_dispenser_coin_inventory.sv | 50 +++++
 rtl/change_dispenser.sv | 156 +++++++++++++++
 tb/tb_change_dispenser.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared vending types: coin values, coin enum, changer FSM states
package change_dispenser_pkg;

  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

  // Encoding doubles as the refill_sel code.
  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } chg_state_e;

  function automatic logic [7:0] coin_value(coin_e c);
    case (c)
      COIN_QUARTER: return 8'(QUARTER_C);
      COIN_DIME:    return 8'(DIME_C);
      COIN_NICKEL:  return 8'(NICKEL_C);
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// rtl/change_dispenser_coin_inventory.sv - per-denomination saturating coin counters with refill/decrement
module coin_inventory
  import change_dispenser_pkg::*;
#(
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [INV_W-1:0] refill_count,
  input  logic             dec_valid,
  input  coin_e            dec_sel,
  output logic [INV_W-1:0] inv_nickel,
  output logic [INV_W-1:0] inv_dime,
  output logic [INV_W-1:0] inv_quarter
);

  // One extra bit catches overflow; a refill and a decrement in the same cycle net out.
  function automatic logic [INV_W-1:0] next_count(logic [INV_W-1:0] cur, logic add,
                                                  logic [INV_W-1:0] amt, logic dec);
    logic [INV_W:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, amt} : {(INV_W+1){1'b0}}) - {{INV_W{1'b0}}, dec};
    return sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
  endfunction

  logic add_n, add_d, add_q;
  logic dec_n, dec_d, dec_q;

  assign add_n = refill_valid && (refill_sel == COIN_NICKEL);
  assign add_d = refill_valid && (refill_sel == COIN_DIME);
  assign add_q = refill_valid && (refill_sel == COIN_QUARTER);
  assign dec_n = dec_valid && (dec_sel == COIN_NICKEL);
  assign dec_d = dec_valid && (dec_sel == COIN_DIME);
  assign dec_q = dec_valid && (dec_sel == COIN_QUARTER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_nickel  <= INV_W'(INV_INIT);
      inv_dime    <= INV_W'(INV_INIT);
      inv_quarter <= INV_W'(INV_INIT);
    end else begin
      inv_nickel  <= next_count(inv_nickel,  add_n, refill_count, dec_n);
      inv_dime    <= next_count(inv_dime,    add_d, refill_count, dec_d);
      inv_quarter <= next_count(inv_quarter, add_q, refill_count, dec_q);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change FSM driving the hopper; inventory tracking under CHANGE_INVENTORY_EN
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int ACK_TIMEOUT = 15
`ifdef CHANGE_INVENTORY_EN
  ,
  parameter int INV_W       = 8,
  parameter int INV_INIT    = 20
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic             eject_quarter,
  output logic             eject_dime,
  output logic             eject_nickel,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] shortfall
`ifdef CHANGE_INVENTORY_EN
  ,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [INV_W-1:0] refill_count,
  output logic [INV_W-1:0] inv_quarter,
  output logic [INV_W-1:0] inv_dime,
  output logic [INV_W-1:0] inv_nickel
`endif
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  chg_state_e       state, state_n;
  coin_e            coin, coin_n, pick;
  logic [AMT_W-1:0] remaining, remaining_n;
  logic [AMT_W-1:0] shortfall_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic             have_q, have_d, have_n;

`ifdef CHANGE_INVENTORY_EN
  coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inventory (
    .clk          (clk),
    .reset        (reset),
    .refill_valid (refill_valid),
    .refill_sel   (refill_sel),
    .refill_count (refill_count),
    .dec_valid    (state == ST_WAIT_ACK && coin_ack),
    .dec_sel      (coin),
    .inv_nickel   (inv_nickel),
    .inv_dime     (inv_dime),
    .inv_quarter  (inv_quarter)
  );

  assign have_q = (inv_quarter != '0);
  assign have_d = (inv_dime != '0);
  assign have_n = (inv_nickel != '0);
`else
  assign have_q = 1'b1;
  assign have_d = 1'b1;
  assign have_n = 1'b1;
`endif

  always_comb begin
    pick = COIN_NONE;
    if (remaining >= AMT_W'(QUARTER_C) && have_q)   pick = COIN_QUARTER;
    else if (remaining >= AMT_W'(DIME_C) && have_d) pick = COIN_DIME;
    else if (remaining >= AMT_W'(NICKEL_C) && have_n) pick = COIN_NICKEL;
  end

  always_comb begin
    state_n     = state;
    coin_n      = coin;
    remaining_n = remaining;
    shortfall_n = shortfall;
    tmo_n       = tmo_cnt;
    case (state)
      ST_IDLE: if (req_valid) begin
        remaining_n = req_amount;
        state_n     = ST_CHECK;
      end
      ST_CHECK: begin
        if (remaining % AMT_W'(NICKEL_C) != '0) begin
          shortfall_n = remaining;
          state_n     = ST_ERROR;
        end else begin
          state_n = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining == '0) begin
          shortfall_n = '0;
          state_n     = ST_DONE;
        end else if (pick != COIN_NONE) begin
          coin_n  = pick;
          state_n = ST_EJECT;
        end else begin
          shortfall_n = remaining;
          state_n     = ST_ERROR;
        end
      end
      ST_EJECT: begin
        tmo_n   = '0;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (coin_ack) begin
          remaining_n = remaining - AMT_W'(coin_value(coin));
          state_n     = ST_SELECT;
        end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
          // Jammed: the coin is presumed not dropped, so remaining is untouched.
          shortfall_n = remaining;
          state_n     = ST_ERROR;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_ERROR: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      coin      <= COIN_NONE;
      remaining <= '0;
      shortfall <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_n;
      coin      <= coin_n;
      remaining <= remaining_n;
      shortfall <= shortfall_n;
      tmo_cnt   <= tmo_n;
    end
  end

  assign req_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign error         = (state == ST_ERROR);
  assign eject_quarter = (state == ST_EJECT) && (coin == COIN_QUARTER);
  assign eject_dime    = (state == ST_EJECT) && (coin == COIN_DIME);
  assign eject_nickel  = (state == ST_EJECT) && (coin == COIN_NICKEL);

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser; inventory tests under CHANGE_INVENTORY_EN
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [5:0] req_amount = '0;
  logic       coin_ack = 1'b0;
  logic       req_ready, eject_quarter, eject_dime, eject_nickel;
  logic       busy, done, error;
  logic [5:0] shortfall;
`ifdef CHANGE_INVENTORY_EN
  logic       refill_valid = 1'b0;
  logic [1:0] refill_sel = '0;
  logic [7:0] refill_count = '0;
  logic [7:0] inv_quarter, inv_dime, inv_nickel;
`endif

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_amount    (req_amount),
    .eject_quarter (eject_quarter),
    .eject_dime    (eject_dime),
    .eject_nickel  (eject_nickel),
    .coin_ack      (coin_ack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .shortfall     (shortfall)
`ifdef CHANGE_INVENTORY_EN
    ,
    .refill_valid  (refill_valid),
    .refill_sel    (refill_sel),
    .refill_count  (refill_count),
    .inv_quarter   (inv_quarter),
    .inv_dime      (inv_dime),
    .inv_nickel    (inv_nickel)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [4:0] EV_N    = 5'b00001;
  localparam logic [4:0] EV_D    = 5'b00010;
  localparam logic [4:0] EV_Q    = 5'b00100;
  localparam logic [4:0] EV_DONE = 5'b01000;
  localparam logic [4:0] EV_ERR  = 5'b10000;

  typedef struct packed {
    logic [4:0] ev;
    logic [5:0] sf;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [4:0] mon_obs;
  int         checks = 0;
  int         failures = 0;
  bit         ack_en = 1'b1;
  int         n;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] ev, input int sf);
    exp_t e;
    e.ev = ev;
    e.sf = sf[5:0];
    sb.push_back(e);
  endtask

  task automatic issue_req(input int amt);
    @(negedge clk);
    req_amount = amt[5:0];
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // which=0 waits for any eject, which=1 for done/error; n counts negedges taken.
  task automatic wait_for(input int which, output int cnt);
    logic hit;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      hit = (which == 0) ? (eject_quarter | eject_dime | eject_nickel) : (done | error);
    end while (!hit && cnt < 100);
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: event %0d not seen within %0d cycles", which, cnt);
    end
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic refill(input int sel, input int cnt);
    @(negedge clk);
    refill_valid = 1'b1;
    refill_sel   = sel[1:0];
    refill_count = cnt[7:0];
    @(negedge clk);
    refill_valid = 1'b0;
  endtask
`endif

  // Scoreboard monitor: every observable pulse must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mon_obs = {error, done, eject_quarter, eject_dime, eject_nickel};
      if (mon_obs != '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got events=%b shortfall=%0d expected nothing", mon_obs, shortfall);
        end else begin
          mon_e = sb.pop_front();
          if (mon_obs != mon_e.ev || ((done || error) && shortfall != mon_e.sf)) begin
            failures++;
            $display("FAIL scoreboard: got events=%b shortfall=%0d expected events=%b shortfall=%0d",
                     mon_obs, shortfall, mon_e.ev, mon_e.sf);
          end
        end
      end
    end
  end

  // Hopper model: acknowledge each eject one cycle after it.
  initial forever begin
    @(negedge clk);
    if (ack_en && !reset && (eject_quarter | eject_dime | eject_nickel)) begin
      @(negedge clk);
      coin_ack = 1'b1;
      @(negedge clk);
      coin_ack = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done_error", {done, error}, 0);
    chk("reset_ejects", {eject_quarter, eject_dime, eject_nickel}, 0);
    chk("reset_shortfall", shortfall, 0);
`ifdef CHANGE_INVENTORY_EN
    chk("reset_inv_quarter", inv_quarter, 20);
    chk("reset_inv_nickel", inv_nickel, 20);
`endif
    reset = 1'b0;

    // 30 cents: quarter + nickel
    push(EV_Q, 0); push(EV_N, 0); push(EV_DONE, 0);
    issue_req(30);
    wait_for(0, n);
    chk("first_eject_latency", n, 3);
    wait_for(1, n);
    chk("req30_shortfall", shortfall, 0);
`ifdef CHANGE_INVENTORY_EN
    chk("req30_inv_quarter", inv_quarter, 19);
    chk("req30_inv_nickel", inv_nickel, 19);
    chk("req30_inv_dime", inv_dime, 20);
`endif

    // zero amount: done only, busy for three cycles
    push(EV_DONE, 0);
    issue_req(0);
    busy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("req0_busy_cycles", busy_cnt, 3);
    chk("req0_ready_after", req_ready, 1);

    // non-multiple of 5
    push(EV_ERR, 17);
    issue_req(17);
    wait_for(1, n);
    chk("req17_error_latency", n, 2);
    chk("req17_shortfall", shortfall, 17);

    // jam: no ack
    ack_en = 1'b0;
    push(EV_Q, 0); push(EV_ERR, 25);
    issue_req(25);
    wait_for(0, n);
    wait_for(1, n);
    chk("timeout_cycles", n, 16);
    chk("timeout_shortfall", shortfall, 25);
`ifdef CHANGE_INVENTORY_EN
    chk("timeout_inv_quarter", inv_quarter, 19);
`endif

    // reset during WAIT_ACK of a 45-cent request
    push(EV_Q, 0);
    issue_req(45);
    wait_for(0, n);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_ejects", {eject_quarter, eject_dime, eject_nickel}, 0);
    chk("midreset_done_error", {done, error}, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_req_ready", req_ready, 1);
    chk("midreset_shortfall", shortfall, 0);
`ifdef CHANGE_INVENTORY_EN
    chk("midreset_inv_quarter", inv_quarter, 20);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset_no_pending", sb.size(), 0);
    ack_en = 1'b1;
    push(EV_D, 0); push(EV_DONE, 0);
    issue_req(10);
    wait_for(1, n);
    chk("req10_shortfall", shortfall, 0);
`ifdef CHANGE_INVENTORY_EN
    chk("req10_inv_dime", inv_dime, 19);

    // bring inventory to quarter=1, dime=0, nickel=2
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      push(EV_Q, 0); push(EV_DONE, 0); issue_req(25); wait_for(1, n);
    end
    for (int i = 0; i < 20; i++) begin
      push(EV_D, 0); push(EV_DONE, 0); issue_req(10); wait_for(1, n);
    end
    for (int i = 0; i < 18; i++) begin
      push(EV_N, 0); push(EV_DONE, 0); issue_req(5); wait_for(1, n);
    end
    chk("drain_inv", {inv_quarter, inv_dime, inv_nickel}, {8'd1, 8'd0, 8'd2});

    push(EV_Q, 0); push(EV_N, 0); push(EV_N, 0); push(EV_ERR, 5);
    issue_req(40);
    wait_for(1, n);
    chk("short40_shortfall", shortfall, 5);
    chk("short40_inv", {inv_quarter, inv_dime, inv_nickel}, 0);

    refill(3, 3);
    chk("refill_quarter", inv_quarter, 3);
    refill(0, 9);
    chk("refill_sel0_ignored", {inv_quarter, inv_dime, inv_nickel}, {8'd3, 8'd0, 8'd0});
    refill(1, 250);
    refill(1, 10);
    chk("refill_saturate", inv_nickel, 255);

    // refill and ack decrement on the same denomination in one cycle
    ack_en = 1'b0;
    push(EV_Q, 0); push(EV_DONE, 0);
    issue_req(25);
    wait_for(0, n);
    @(negedge clk);
    coin_ack     = 1'b1;
    refill_valid = 1'b1;
    refill_sel   = 2'd3;
    refill_count = 8'd4;
    @(negedge clk);
    coin_ack     = 1'b0;
    refill_valid = 1'b0;
    wait_for(1, n);
    chk("refill_and_dec", inv_quarter, 6);
    ack_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
